// File: rtl/ksa_if.sv
// ---------------------------------------------------------------------------
// ksa_if -- bundle between the RC4 key-scheduling engine, its controller and
// the single-port S-box RAM.
//
//   start    controller -> engine  one-cycle run request
//   mode     controller -> engine  00 full, 01 init only, 10 shuffle only, 11 no-op
//   key      controller -> engine  KEY_BYTES words of ADDR_W bits, word 0 in the MSBs
//   address  engine -> RAM         RAM address
//   wren     engine -> RAM         RAM write enable
//   data     engine -> RAM         RAM write data
//   q        RAM -> engine         read data, valid the cycle after its address
//   busy     engine -> controller  run in progress
//   done     engine -> controller  one-cycle end-of-run pulse
//
// master: the engine side.  slave: the controller/RAM side.
// ---------------------------------------------------------------------------
interface ksa_if #(
   parameter int ADDR_W    = 8,
   parameter int KEY_BYTES = 3
);
   logic                          start;
   logic [1:0]                    mode;
   logic [KEY_BYTES*ADDR_W-1:0]   key;
   logic [ADDR_W-1:0]             address;
   logic                          wren;
   logic [ADDR_W-1:0]             data;
   logic [ADDR_W-1:0]             q;
   logic                          busy;
   logic                          done;

   modport master (
      input  start, mode, key, q,
      output address, wren, data, busy, done
   );

   modport slave (
      output start, mode, key, q,
      input  address, wren, data, busy, done
   );
endinterface

// File: rtl/ksa_engine.sv
// ---------------------------------------------------------------------------
// ksa_engine -- parametrised RC4 key-scheduling engine driving a single-port
// synchronous S-box RAM of 2^ADDR_W words of ADDR_W bits.
//
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      ksa_if.master: start/mode/key/busy/done towards the controller,
//            address/wren/data/q towards the S-box RAM
//
// Phases: init writes S[i]=i (one cycle per entry); shuffle performs the
// key-driven swap in six cycles per entry because the RAM has one port and
// one cycle of read latency.  Every output is registered on entry to the
// state it belongs to, so the bus values seen in a cycle are those of the
// current state.
// ---------------------------------------------------------------------------
module ksa_engine #(
   parameter int ADDR_W    = 8,
   parameter int KEY_BYTES = 3
) (
   input  logic   clk,
   input  logic   reset_n,
   ksa_if.master  bus
);

   localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      SH_ADDR_I,
      SH_READ_I,
      SH_ADDR_J,
      SH_READ_J,
      SH_WR_I,
      SH_WR_J,
      FIN
   } state_t;

   state_t                        state_reg;
   logic [ADDR_W-1:0]             i_reg;
   logic [ADDR_W-1:0]             j_reg;
   logic [ADDR_W-1:0]             si_reg;
   logic [KI_W-1:0]               k_idx_reg;
   logic [KEY_BYTES*ADDR_W-1:0]   key_reg;
   logic [1:0]                    mode_reg;
   logic [ADDR_W-1:0]             address_reg;
   logic [ADDR_W-1:0]             data_reg;
   logic                          wren_reg;
   logic                          busy_reg;
   logic                          done_reg;

   // Latched key split into words; word 0 sits in the most-significant bits.
   logic [ADDR_W-1:0] key_words [KEY_BYTES];

   generate
      for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_words
         assign key_words[gi] = key_reg[(KEY_BYTES-1-gi)*ADDR_W +: ADDR_W];
      end
   endgenerate

   logic              last_i;
   logic              last_k;
   logic [ADDR_W-1:0] j_sum;
   logic [ADDR_W-1:0] i_inc;

   assign last_i = (i_reg == {ADDR_W{1'b1}});
   assign last_k = (k_idx_reg == KI_W'(KEY_BYTES - 1));
   assign i_inc  = i_reg + 1'b1;
   // q holds S[i] during SH_READ_I; the sum wraps at the word width.
   assign j_sum  = j_reg + bus.q + key_words[k_idx_reg];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         i_reg       <= '0;
         j_reg       <= '0;
         si_reg      <= '0;
         k_idx_reg   <= '0;
         key_reg     <= '0;
         mode_reg    <= 2'b00;
         address_reg <= '0;
         data_reg    <= '0;
         wren_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  key_reg   <= bus.key;
                  mode_reg  <= bus.mode;
                  i_reg     <= '0;
                  j_reg     <= '0;
                  k_idx_reg <= '0;
                  case (bus.mode)
                     2'b00, 2'b01: begin
                        state_reg   <= INIT;
                        busy_reg    <= 1'b1;
                        address_reg <= '0;
                        data_reg    <= '0;
                        wren_reg    <= 1'b1;
                     end
                     2'b10: begin
                        state_reg   <= SH_ADDR_I;
                        busy_reg    <= 1'b1;
                        address_reg <= '0;
                        wren_reg    <= 1'b0;
                     end
                     default: begin
                        // No-op: straight to the done pulse, never busy.
                        state_reg <= FIN;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                     end
                  endcase
               end
            end

            INIT: begin
               if (last_i) begin
                  i_reg    <= '0;
                  wren_reg <= 1'b0;
                  if (mode_reg == 2'b00) begin
                     state_reg   <= SH_ADDR_I;
                     address_reg <= '0;
                  end else begin
                     state_reg <= FIN;
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                  end
               end else begin
                  i_reg       <= i_inc;
                  address_reg <= i_inc;
                  data_reg    <= i_inc;
               end
            end

            SH_ADDR_I: state_reg <= SH_READ_I;

            SH_READ_I: begin
               si_reg      <= bus.q;
               j_reg       <= j_sum;
               address_reg <= j_sum;
               state_reg   <= SH_ADDR_J;
            end

            SH_ADDR_J: state_reg <= SH_READ_J;

            SH_READ_J: begin
               // q is S[j]; write it to S[i] straight from the RAM output.
               address_reg <= i_reg;
               data_reg    <= bus.q;
               wren_reg    <= 1'b1;
               state_reg   <= SH_WR_I;
            end

            SH_WR_I: begin
               address_reg <= j_reg;
               data_reg    <= si_reg;
               wren_reg    <= 1'b1;
               state_reg   <= SH_WR_J;
            end

            SH_WR_J: begin
               wren_reg  <= 1'b0;
               i_reg     <= i_inc;
               k_idx_reg <= last_k ? '0 : k_idx_reg + 1'b1;
               if (last_i) begin
                  state_reg <= FIN;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
               end else begin
                  state_reg   <= SH_ADDR_I;
                  address_reg <= i_inc;
               end
            end

            FIN: state_reg <= IDLE;

            default: begin
               state_reg <= IDLE;
               wren_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.address = address_reg;
   assign bus.data    = data_reg;
   assign bus.wren    = wren_reg;
   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;

endmodule

// File: tb/tb_ksa_engine.sv
// ---------------------------------------------------------------------------
// tb_ksa_engine -- randomized scoreboard bench for ksa_engine.
// Two instances: default (ADDR_W=8, KEY_BYTES=3) and small (ADDR_W=4,
// KEY_BYTES=1), each with its own S-box RAM. Stimulus pushes the expected
// latency, write count and final S-box; a monitor checks them at each done.
// ---------------------------------------------------------------------------
module tb_ksa_engine;

   localparam int AW_A = 8;
   localparam int KB_A = 3;
   localparam int N_A  = 256;
   localparam int AW_B = 4;
   localparam int KB_B = 1;
   localparam int N_B  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   ksa_if #(.ADDR_W(AW_A), .KEY_BYTES(KB_A)) bus_a ();
   ksa_if #(.ADDR_W(AW_B), .KEY_BYTES(KB_B)) bus_b ();

   ksa_engine #(.ADDR_W(AW_A), .KEY_BYTES(KB_A)) dut_a (
      .clk(clk), .reset_n(rst_a), .bus(bus_a));
   ksa_engine #(.ADDR_W(AW_B), .KEY_BYTES(KB_B)) dut_b (
      .clk(clk), .reset_n(rst_b), .bus(bus_b));

   // Single-port synchronous RAMs, read data one cycle after the address.
   logic [7:0] ram_a [256];
   logic [3:0] ram_b [16];

   always @(posedge clk) begin
      if (bus_a.wren) ram_a[bus_a.address] <= bus_a.data;
      bus_a.q <= ram_a[bus_a.address];
      if (bus_b.wren) ram_b[bus_b.address] <= bus_b.data;
      bus_b.q <= ram_b[bus_b.address];
   end

   // Scoreboard queues
   int           lat_qa[$], wr_qa[$], st_qa[$];
   logic [2047:0] sb_qa[$];
   int           lat_qb[$], wr_qb[$], st_qb[$];
   logic [2047:0] sb_qb[$];
   logic [2047:0] model_a = '0;
   logic [2047:0] model_b = '0;

   // ---------------- reference model ----------------
   function automatic logic [2047:0] ksa_ref(input logic [2047:0] s_in, input int n,
                                             input int aw, input int kb,
                                             input logic [23:0] key, input logic [1:0] m);
      int s[256];
      int j, t, kw;
      logic [2047:0] r;
      for (int k = 0; k < 256; k++) s[k] = int'(s_in[k*8 +: 8]);
      if (m == 2'b00 || m == 2'b01)
         for (int k = 0; k < n; k++) s[k] = k;
      if (m == 2'b00 || m == 2'b10) begin
         j = 0;
         for (int i = 0; i < n; i++) begin
            kw = int'(key >> ((kb - 1 - (i % kb)) * aw)) & (n - 1);
            j = (j + s[i] + kw) % n;
            t = s[i]; s[i] = s[j]; s[j] = t;
         end
      end
      r = '0;
      for (int k = 0; k < 256; k++) r[k*8 +: 8] = 8'(s[k]);
      return r;
   endfunction

   function automatic int exp_lat(input logic [1:0] m, input int n);
      case (m)
         2'b00:   return 7 * n + 1;
         2'b01:   return n + 1;
         2'b10:   return 6 * n + 1;
         default: return 1;
      endcase
   endfunction

   function automatic int exp_wr(input logic [1:0] m, input int n);
      case (m)
         2'b00:   return 3 * n;
         2'b01:   return n;
         2'b10:   return 2 * n;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      int wa, wb, el, ew, sc, bad, first_bad;
      logic [2047:0] es;
      wa = 0; wb = 0;
      forever begin
         @(negedge clk);
         if (!rst_a) wa = 0;
         else begin
            if (bus_a.wren) wa++;
            if (bus_a.done) begin
               if (lat_qa.size() == 0) begin
                  check("unexpected_done_a", 1, 0);
               end else begin
                  el = lat_qa.pop_front(); ew = wr_qa.pop_front();
                  sc = st_qa.pop_front();  es = sb_qa.pop_front();
                  bad = 0; first_bad = -1;
                  for (int k = 0; k < N_A; k++)
                     if (int'(ram_a[k]) != int'(es[k*8 +: 8])) begin
                        bad++;
                        if (first_bad < 0) first_bad = k;
                     end
                  check("latency_a", longint'(cyc - sc), longint'(el));
                  check("writes_a", longint'(wa), longint'(ew));
                  check("sbox_a_bad_entries", longint'(bad), 0);
                  $display("run a: latency=%0d writes=%0d bad_entries=%0d first_bad=%0d",
                           cyc - sc, wa, bad, first_bad);
               end
               wa = 0;
            end
         end
         if (!rst_b) wb = 0;
         else begin
            if (bus_b.wren) wb++;
            if (bus_b.done) begin
               if (lat_qb.size() == 0) begin
                  check("unexpected_done_b", 1, 0);
               end else begin
                  el = lat_qb.pop_front(); ew = wr_qb.pop_front();
                  sc = st_qb.pop_front();  es = sb_qb.pop_front();
                  bad = 0; first_bad = -1;
                  for (int k = 0; k < N_B; k++)
                     if (int'(ram_b[k]) != int'(es[k*8 +: 8])) begin
                        bad++;
                        if (first_bad < 0) first_bad = k;
                     end
                  check("latency_b", longint'(cyc - sc), longint'(el));
                  check("writes_b", longint'(wb), longint'(ew));
                  check("sbox_b_bad_entries", longint'(bad), 0);
                  $display("run b: latency=%0d writes=%0d bad_entries=%0d first_bad=%0d",
                           cyc - sc, wb, bad, first_bad);
               end
               wb = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_a(input logic [1:0] m, input logic [23:0] k);
      @(negedge clk);
      bus_a.start = 1'b1; bus_a.mode = m; bus_a.key = k;
      model_a = ksa_ref(model_a, N_A, AW_A, KB_A, k, m);
      lat_qa.push_back(exp_lat(m, N_A)); wr_qa.push_back(exp_wr(m, N_A));
      sb_qa.push_back(model_a);          st_qa.push_back(cyc);
      @(negedge clk);
      bus_a.start = 1'b0;
   endtask

   task automatic start_b(input logic [1:0] m, input logic [3:0] k);
      @(negedge clk);
      bus_b.start = 1'b1; bus_b.mode = m; bus_b.key = k;
      model_b = ksa_ref(model_b, N_B, AW_B, KB_B, {20'd0, k}, m);
      lat_qb.push_back(exp_lat(m, N_B)); wr_qb.push_back(exp_wr(m, N_B));
      sb_qb.push_back(model_b);          st_qb.push_back(cyc);
      @(negedge clk);
      bus_b.start = 1'b0;
   endtask

   task automatic wait_a(input int budget);
      int n = 0;
      while (lat_qa.size() != 0 && n < budget) begin @(negedge clk); n++; end
      if (lat_qa.size() != 0) begin
         check("timeout_a", longint'(lat_qa.size()), 0);
         lat_qa.delete(); wr_qa.delete(); st_qa.delete(); sb_qa.delete();
      end
   endtask

   task automatic wait_b(input int budget);
      int n = 0;
      while (lat_qb.size() != 0 && n < budget) begin @(negedge clk); n++; end
      if (lat_qb.size() != 0) begin
         check("timeout_b", longint'(lat_qb.size()), 0);
         lat_qb.delete(); wr_qb.delete(); st_qb.delete(); sb_qb.delete();
      end
   endtask

   // ---------------- main stimulus ----------------
   initial begin : stimulus
      int c, wcount;
      logic [23:0] k0;
      rst_a = 1'b0; rst_b = 1'b0;
      bus_a.start = 1'b0; bus_a.mode = 2'b00; bus_a.key = '0;
      bus_b.start = 1'b0; bus_b.mode = 2'b00; bus_b.key = '0;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_wren_a", longint'(bus_a.wren), 0);
      check("reset_busy_a", longint'(bus_a.busy), 0);
      check("reset_done_a", longint'(bus_a.done), 0);
      check("reset_addr_a", longint'(bus_a.address), 0);
      check("reset_wren_b", longint'(bus_b.wren), 0);
      check("reset_addr_b", longint'(bus_b.address), 0);
      rst_a = 1'b1; rst_b = 1'b1;

      // Default instance: directed runs
      start_a(2'b01, 24'h000000);  wait_a(3000);
      start_a(2'b00, 24'h000000);  wait_a(3000);
      start_a(2'b00, 24'h00033C);  wait_a(3000);
      start_a(2'b10, 24'($urandom)); wait_a(3000);
      start_a(2'b11, 24'($urandom)); wait_a(100);

      // start pulses and key changes while busy, then a start in the FIN cycle
      k0 = 24'($urandom);
      start_a(2'b00, k0);
      c = cyc - 1;
      for (int p = 0; p < 4; p++) begin
         repeat ($urandom_range(50, 300)) @(negedge clk);
         bus_a.start = 1'b1; bus_a.mode = 2'($urandom_range(0, 3)); bus_a.key = 24'($urandom);
         @(negedge clk);
         bus_a.start = 1'b0;
      end
      while (cyc < c + 7 * N_A + 1) @(negedge clk);
      check("fin_done_a", longint'(bus_a.done), 1);
      bus_a.start = 1'b1; bus_a.mode = 2'b01;
      @(negedge clk);
      bus_a.start = 1'b0;
      check("fin_start_ignored_a", longint'(bus_a.busy), 0);
      wait_a(3000);

      // Reset during shuffle at i=100, SH_WR_I
      k0 = 24'($urandom);
      start_a(2'b00, k0);
      c = cyc - 1;
      while (cyc < c + 1 + N_A + 6 * 100 + 4) @(negedge clk);
      check("abort_addr_a", longint'(bus_a.address), 100);
      check("abort_wren_hi_a", longint'(bus_a.wren), 1);
      rst_a = 1'b0;
      lat_qa.delete(); wr_qa.delete(); st_qa.delete(); sb_qa.delete();
      @(negedge clk);
      check("abort_wren_drop_a", longint'(bus_a.wren), 0);
      wcount = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus_a.wren) wcount++;
      end
      check("abort_no_writes_a", longint'(wcount), 0);
      check("abort_busy_a", longint'(bus_a.busy), 0);
      rst_a = 1'b1;
      $display("run a: aborted by reset at i=100");
      start_a(2'b00, k0);  wait_a(3000);
      for (int r = 0; r < 3; r++) begin
         start_a(2'($urandom_range(0, 3)), 24'($urandom));
         wait_a(3000);
      end

      // Small instance
      start_b(2'b00, 4'hA);  wait_b(300);
      start_b(2'b11, 4'h5);  wait_b(50);
      for (int r = 0; r < 20; r++) begin
         start_b(2'($urandom_range(0, 3)), 4'($urandom));
         wait_b(300);
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
